// File: rtl/sim_run_ctrl.sv
// Cycle-counted run controller: sequences SOC reset, counts cycles/instructions,
// ends the run on a tohost store, a PC self-loop or a watchdog timeout.
module sim_run_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 32,
  parameter int                RST_CYCLES  = 3,
  parameter int                TIMEOUT     = 200,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_0100,
  parameter logic [DATA_W-1:0] PASS_VALUE  = 32'h0000_0001,
  parameter int                LOOP_CYCLES = 8,
  parameter int                AUTO_START  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              soc_rst,
  output logic              soc_hold,
  output logic              running,
  output logic              done,
  output logic [2:0]        result,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [DATA_W-1:0] tohost_data
);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  localparam logic [31:0]      RST_M1  = 32'(RST_CYCLES - 1);
  localparam logic [31:0]      LOOP_M2 = 32'((LOOP_CYCLES > 1) ? LOOP_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t            state;
  logic [31:0]       rst_cnt;
  logic [ADDR_W-1:0] last_pc;
  logic [31:0]       loop_cnt;
  logic              have_pc;

  logic go_reset, pc_match, e_tohost, e_loop, e_timeout;

  assign go_reset  = ((state == S_IDLE) && ((AUTO_START != 0) || start)) ||
                     ((state == S_DONE) && start);
  // The first valid PC after RESET only seeds last_pc, it never counts as a repeat
  assign pc_match  = pc_valid && have_pc && (pc == last_pc);
  assign e_tohost  = mem_we && (mem_addr == TOHOST_ADDR);
  assign e_loop    = (LOOP_CYCLES == 1) ? pc_valid
                   : ((LOOP_CYCLES > 1) && pc_match && (loop_cnt == LOOP_M2));
  assign e_timeout = (TIMEOUT > 0) && (cycle_cnt == TO_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      soc_rst     <= 1'b1;
      soc_hold    <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      result      <= 3'd0;
      cycle_cnt   <= '0;
      instr_cnt   <= '0;
      tohost_data <= '0;
      rst_cnt     <= '0;
      last_pc     <= '0;
      loop_cnt    <= '0;
      have_pc     <= 1'b0;
    end else if (go_reset) begin
      state       <= S_RESET;
      soc_rst     <= 1'b1;
      soc_hold    <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      result      <= 3'd0;
      cycle_cnt   <= '0;
      instr_cnt   <= '0;
      tohost_data <= '0;
      rst_cnt     <= '0;
      last_pc     <= '0;
      loop_cnt    <= '0;
      have_pc     <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          if (rst_cnt == RST_M1) begin
            state   <= S_RUN;
            soc_rst <= 1'b0;
            running <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 32'd1;
          end
        end
        S_RUN: begin
          if (!(&cycle_cnt)) cycle_cnt <= cycle_cnt + ONE;
          if (pc_valid && !(&instr_cnt)) instr_cnt <= instr_cnt + ONE;
          if (pc_valid) begin
            if (pc_match) begin
              loop_cnt <= loop_cnt + 32'd1;
            end else begin
              last_pc  <= pc;
              loop_cnt <= '0;
              have_pc  <= 1'b1;
            end
          end
          if (e_tohost || e_loop || e_timeout) begin
            state    <= S_DONE;
            running  <= 1'b0;
            done     <= 1'b1;
            soc_hold <= 1'b1;
            if (e_tohost) begin
              result      <= (mem_wdata == PASS_VALUE) ? 3'd1 : 3'd2;
              tohost_data <= mem_wdata;
            end else if (e_loop) begin
              result <= 3'd4;
            end else begin
              result <= 3'd3;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: directed and random runs scored against a trace-level outcome model.
module tb_sim_run_ctrl;

  localparam int          NCYC    = 256;
  localparam int          RSTC    = 3;
  localparam int          TMO     = 200;
  localparam int          LOOPN   = 8;
  localparam logic [31:0] TOHOST  = 32'h0000_0100;
  localparam logic [31:0] PASSV   = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst, start, m_rst, m_start;
  logic [31:0] pc, mem_addr, mem_wdata;
  logic        pc_valid, mem_we;
  logic        soc_rst, soc_hold, running, done;
  logic [2:0]  result;
  logic [31:0] cycle_cnt, instr_cnt, tohost_data;
  logic        m_soc_rst, m_soc_hold, m_running, m_done;
  logic [2:0]  m_result;
  logic [31:0] m_cycle_cnt, m_instr_cnt, m_tohost_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] a_pc[NCYC], a_addr[NCYC], a_wd[NCYC];
  bit          a_val[NCYC], a_we[NCYC];

  always #5 clk = ~clk;

  sim_run_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_valid(pc_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .soc_rst(soc_rst), .soc_hold(soc_hold), .running(running), .done(done),
    .result(result), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
    .tohost_data(tohost_data)
  );

  sim_run_ctrl #(.AUTO_START(0)) u_man (
    .clk(clk), .rst(m_rst), .start(m_start), .pc(pc), .pc_valid(pc_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .soc_rst(m_soc_rst), .soc_hold(m_soc_hold), .running(m_running), .done(m_done),
    .result(m_result), .cycle_cnt(m_cycle_cnt), .instr_cnt(m_instr_cnt),
    .tohost_data(m_tohost_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    pc = '0; pc_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic drive(input int i);
    pc = a_pc[i]; pc_valid = a_val[i]; mem_we = a_we[i];
    mem_addr = a_addr[i]; mem_wdata = a_wd[i];
  endtask

  // Kinds: 0 pass@50, 1 fail@50, 2 store to 0x104, 3 loop from 10, 4 timeout,
  // 5 tohost+loop+timeout together, 6 random mix.
  task automatic gen(input int kind);
    logic [31:0] cur;
    cur = 32'h0;
    for (int i = 0; i < NCYC; i++) begin
      a_val[i]  = ($urandom % 2) == 1;
      a_pc[i]   = 32'h1000 + 32'(i) * 4;
      a_we[i]   = ($urandom % 8) == 0;
      a_addr[i] = 32'h200 + ($urandom % 16) * 4;
      a_wd[i]   = $urandom;
      if (kind == 6) begin
        if (($urandom % 3) == 0) cur = $urandom_range(0, 3) * 4;
        a_val[i]  = ($urandom % 4) != 0;
        a_pc[i]   = cur;
        a_we[i]   = ($urandom % 64) == 0;
        a_addr[i] = (($urandom % 2) == 1) ? TOHOST : 32'h104;
        a_wd[i]   = (($urandom % 2) == 1) ? PASSV : $urandom;
      end
      if (kind == 3 && i >= 10) begin a_val[i] = 1'b1; a_pc[i] = 32'h40; end
      if (kind == 5 && i >= 192) begin a_val[i] = 1'b1; a_pc[i] = 32'h40; end
    end
    if (kind <= 2) begin
      a_we[50]   = 1'b1;
      a_addr[50] = (kind == 2) ? 32'h104 : TOHOST;
      a_wd[50]   = (kind == 1) ? 32'hDEAD : PASSV;
    end
    if (kind == 5) begin a_we[199] = 1'b1; a_addr[199] = TOHOST; a_wd[199] = PASSV; end
  endtask

  // Outcome of a run from its input trace: run-length of equal valid PCs, first event wins.
  function automatic void model(output int e, output int r, output int ic, output logic [31:0] th);
    int run; logic [31:0] prev; bit have;
    run = 0; prev = '0; have = 0; e = -1; r = 0; ic = 0; th = '0;
    for (int i = 0; i < NCYC; i++) begin
      if (a_val[i]) begin
        ic++;
        if (have && a_pc[i] == prev) run++;
        else begin run = 1; prev = a_pc[i]; have = 1; end
      end
      if (a_we[i] && a_addr[i] == TOHOST) begin
        r = (a_wd[i] == PASSV) ? 1 : 2; th = a_wd[i];
      end else if (a_val[i] && run == LOOPN) r = 4;
      else if (i == TMO - 1) r = 3;
      if (r != 0) begin e = i; return; end
    end
  endfunction

  task automatic restart(input string nm);
    int n;
    n = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk({nm, "/clr_cycle"}, cycle_cnt, 0);
    chk({nm, "/clr_instr"}, instr_cnt, 0);
    chk({nm, "/clr_result"}, result, 0);
    chk({nm, "/clr_tohost"}, tohost_data, 0);
    chk({nm, "/clr_done"}, done, 0);
    while (!running && n < 20) begin
      if (soc_rst) n++;
      @(negedge clk);
    end
    chk({nm, "/rst_len"}, n, RSTC);
  endtask

  task automatic do_run(input string nm);
    int e, r, ic, i, k; logic [31:0] th; bit ended;
    model(e, r, ic, th);
    k = 0;
    while (!running && k < 20) begin @(negedge clk); k++; end
    chk({nm, "/running"}, running, 1);
    chk({nm, "/soc_rst_low"}, soc_rst, 0);
    chk({nm, "/cnt_start"}, cycle_cnt, 0);
    i = 0; ended = 0;
    while (i < NCYC && !ended) begin
      drive(i);
      start = (i == 20);
      @(negedge clk);
      if (done) ended = 1; else i++;
    end
    bus_idle(); start = 1'b0;
    chk({nm, "/end_cycle"}, i, e);
    chk({nm, "/result"}, result, r);
    chk({nm, "/cycle_cnt"}, cycle_cnt, e + 1);
    chk({nm, "/instr_cnt"}, instr_cnt, ic);
    chk({nm, "/tohost"}, tohost_data, th);
    chk({nm, "/soc_hold"}, soc_hold, 1);
    chk({nm, "/running_off"}, running, 0);
    // Bus activity while DONE must leave everything frozen
    mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = ~th; pc_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus_idle();
    chk({nm, "/frz_cycle"}, cycle_cnt, e + 1);
    chk({nm, "/frz_result"}, result, r);
    chk({nm, "/frz_tohost"}, tohost_data, th);
    chk({nm, "/frz_instr"}, instr_cnt, ic);
  endtask

  initial begin
    int n;
    rst = 1'b0; m_rst = 1'b0; start = 1'b0; m_start = 1'b0;
    bus_idle();
    @(negedge clk);
    chk("rst/soc_rst", soc_rst, 1);
    chk("rst/soc_hold", soc_hold, 0);
    chk("rst/running", running, 0);
    chk("rst/done", done, 0);
    chk("rst/result", result, 0);
    chk("rst/cycle_cnt", cycle_cnt, 0);
    chk("rst/instr_cnt", instr_cnt, 0);
    chk("rst/tohost", tohost_data, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1; m_rst = 1'b1;
    for (int k = 0; k < RSTC; k++) begin
      @(negedge clk);
      chk("boot/soc_rst_hi", soc_rst, 1);
      chk("boot/not_running", running, 0);
    end
    @(negedge clk);
    chk("boot/soc_rst_lo", soc_rst, 0);
    chk("boot/running", running, 1);

    gen(0); do_run("pass");
    restart("r1"); gen(1); do_run("fail");
    restart("r2"); gen(2); do_run("addr104");
    restart("r3"); gen(3); do_run("loop");
    restart("r4"); gen(4); do_run("timeout");
    restart("r5"); gen(5); do_run("priority");
    for (int t = 0; t < 6; t++) begin
      restart("rr"); gen(6); do_run("rand");
    end

    // Reset mid-run, with a tohost store pending in the same cycle
    restart("r6"); gen(4);
    for (int i = 0; i < 30; i++) begin drive(i); @(negedge clk); end
    mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = PASSV;
    #2 rst = 1'b0;
    #1;
    chk("midrst/soc_rst", soc_rst, 1);
    chk("midrst/running", running, 0);
    chk("midrst/cycle_cnt", cycle_cnt, 0);
    chk("midrst/result", result, 0);
    bus_idle();
    @(negedge clk); rst = 1'b1;
    gen(0); do_run("after_rst");

    // Manual-start instance must sit in IDLE until start
    chk("man/idle_soc_rst", m_soc_rst, 1);
    chk("man/idle_running", m_running, 0);
    m_start = 1'b1; @(negedge clk); m_start = 1'b0;
    n = 0;
    while (!m_running && n < 20) begin
      if (m_soc_rst) n++;
      @(negedge clk);
    end
    chk("man/rst_len", n, RSTC);
    chk("man/running", m_running, 1);
    repeat (5) @(negedge clk);
    #2 m_rst = 1'b0;
    #1;
    chk("man/midrst_running", m_running, 0);
    chk("man/midrst_soc_rst", m_soc_rst, 1);
    @(negedge clk); m_rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("man/wait_running", m_running, 0);
    chk("man/wait_soc_rst", m_soc_rst, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
